// File: rtl/easyaxi_pkg.sv
// Shared definitions for the EasyAXI read-request path: FSM encoding and default widths.
package easyaxi_pkg;

    localparam int DEF_DEEP_NUM   = 8;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_ID_WIDTH   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/easyaxi_onehot_mux.sv
// One-hot AND-OR multiplexer with a one-hot-to-index encoder for the select vector.
module easyaxi_onehot_mux #(
    parameter int N     = 8,
    parameter int W     = 40,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]        i_sel,
    input  logic [N-1:0][W-1:0] i_data,
    output logic [W-1:0]        o_data,
    output logic [IDX_W-1:0]    o_idx
);

    always_comb begin
        o_data = '0;
        o_idx  = '0;
        for (int k = 0; k < N; k++) begin
            if (i_sel[k]) begin
                o_data = o_data | i_data[k];
                o_idx  = o_idx | IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/easyaxi_rd_req_buf.sv
// Read-request buffer feeding the round-robin arbiter; issues the granted slot on AR
// and retires it on the matching R last beat.
module easyaxi_rd_req_buf
    import easyaxi_pkg::*;
#(
    parameter int DEEP_NUM   = DEF_DEEP_NUM,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic [DEEP_NUM-1:0]   queue_o,
    output logic                  sche_en_o,
    input  logic [DEEP_NUM-1:0]   pointer_i,
    output logic                  axi_mst_arvalid,
    input  logic                  axi_mst_arready,
    output logic [ADDR_WIDTH-1:0] axi_mst_araddr,
    output logic [LEN_WIDTH-1:0]  axi_mst_arlen,
    output logic [ID_WIDTH-1:0]   axi_mst_arid,
    input  logic                  axi_mst_rvalid,
    input  logic                  axi_mst_rready,
    input  logic                  axi_mst_rlast,
    input  logic [ID_WIDTH-1:0]   axi_mst_rid
);

    localparam int PW = ADDR_WIDTH + LEN_WIDTH;

    rd_state_e r_state, w_state_nxt;

    logic [DEEP_NUM-1:0]   r_valid;
    logic [DEEP_NUM-1:0]   r_issued;
    logic [ADDR_WIDTH-1:0] r_addr [DEEP_NUM];
    logic [LEN_WIDTH-1:0]  r_len  [DEEP_NUM];

    logic [DEEP_NUM-1:0]         w_queue;
    logic [DEEP_NUM-1:0]         w_empty;
    logic [DEEP_NUM-1:0]         w_alloc_oh;
    logic [DEEP_NUM-1:0]         w_free_oh;
    logic [DEEP_NUM-1:0]         w_set_iss;
    logic                        w_req_fire;
    logic                        w_ar_fire;
    logic                        w_r_done;
    logic                        w_arvalid;
    logic                        w_sche_en;
    logic [DEEP_NUM-1:0][PW-1:0] w_payload;
    logic [PW-1:0]               w_sel_payload;
    logic [ID_WIDTH-1:0]         w_sel_idx;

    assign w_queue    = r_valid & ~r_issued;
    assign w_empty    = ~r_valid;
    assign req_ready  = ~(&r_valid);
    assign w_req_fire = req_valid & req_ready;
    // Lowest set bit of the empty mask selects the slot to fill.
    assign w_alloc_oh = w_req_fire ? (w_empty & (~w_empty + DEEP_NUM'(1))) : '0;
    assign w_ar_fire  = w_arvalid & axi_mst_arready;
    assign w_set_iss  = w_ar_fire ? (pointer_i & w_queue) : '0;
    assign w_r_done   = axi_mst_rvalid & axi_mst_rready & axi_mst_rlast;

    always_comb begin
        w_free_oh = '0;
        for (int k = 0; k < DEEP_NUM; k++) begin
            w_free_oh[k] = w_r_done && (axi_mst_rid == ID_WIDTH'(k))
                           && r_valid[k] && r_issued[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sche_en   = 1'b0;
        w_arvalid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sche_en = |w_queue;
                if (|w_queue) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (pointer_i == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_arvalid = 1'b1;
                    if (axi_mst_arready) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_valid  <= '0;
            r_issued <= '0;
        end else begin
            r_state <= w_state_nxt;
            for (int k = 0; k < DEEP_NUM; k++) begin
                if (w_alloc_oh[k]) begin
                    r_valid[k]  <= 1'b1;
                    r_issued[k] <= 1'b0;
                end else if (w_free_oh[k]) begin
                    r_valid[k]  <= 1'b0;
                    r_issued[k] <= 1'b0;
                end else if (w_set_iss[k]) begin
                    r_issued[k] <= 1'b1;
                end
            end
        end
    end

    // Payload storage carries no reset; it is only observed through valid slots.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEEP_NUM; k++) begin
            if (w_alloc_oh[k]) begin
                r_addr[k] <= req_addr;
                r_len[k]  <= req_len;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DEEP_NUM; k++) begin
            w_payload[k] = {r_addr[k], r_len[k]};
        end
    end

    easyaxi_onehot_mux #(
        .N     (DEEP_NUM),
        .W     (PW),
        .IDX_W (ID_WIDTH)
    ) u_ar_mux (
        .i_sel  (pointer_i),
        .i_data (w_payload),
        .o_data (w_sel_payload),
        .o_idx  (w_sel_idx)
    );

    assign queue_o         = w_queue;
    assign sche_en_o       = w_sche_en;
    assign axi_mst_arvalid = w_arvalid;
    assign axi_mst_araddr  = w_arvalid ? w_sel_payload[PW-1:LEN_WIDTH] : '0;
    assign axi_mst_arlen   = w_arvalid ? w_sel_payload[LEN_WIDTH-1:0] : '0;
    assign axi_mst_arid    = w_arvalid ? w_sel_idx : '0;

endmodule

// File: tb/tb_easyaxi_rd_req_buf.sv
// Bench for easyaxi_rd_req_buf with a round-robin arbiter stand-in and a slot-level reference model.
module tb_easyaxi_rd_req_buf;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [N-1:0]  queue_o;
    logic          sche_en_o;
    logic [N-1:0]  arb_ptr = '0;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [IW-1:0] arid;
    logic          rvalid = 1'b0;
    logic          rready = 1'b0;
    logic          rlast = 1'b0;
    logic [IW-1:0] rid = '0;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int arb_last = N - 1;

    bit            m_valid  [N];
    bit            m_issued [N];
    logic [AW-1:0] m_addr   [N];
    logic [LW-1:0] m_len    [N];
    bit            m_armed = 1'b0;

    int ar_ids[$];
    int ar_cyc[$];

    easyaxi_rd_req_buf dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .queue_o         (queue_o),
        .sche_en_o       (sche_en_o),
        .pointer_i       (arb_ptr),
        .axi_mst_arvalid (arvalid),
        .axi_mst_arready (arready),
        .axi_mst_araddr  (araddr),
        .axi_mst_arlen   (arlen),
        .axi_mst_arid    (arid),
        .axi_mst_rvalid  (rvalid),
        .axi_mst_rready  (rready),
        .axi_mst_rlast   (rlast),
        .axi_mst_rid     (rid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [N-1:0] m_pending();
        logic [N-1:0] p = '0;
        for (int k = 0; k < N; k++) p[k] = m_valid[k] && !m_issued[k];
        return p;
    endfunction

    function automatic int m_occupied();
        int c = 0;
        for (int k = 0; k < N; k++) if (m_valid[k]) c++;
        return c;
    endfunction

    function automatic int ptr_index(input logic [N-1:0] p);
        int idx = 0;
        for (int k = 0; k < N; k++) if (p[k]) idx = k;
        return idx;
    endfunction

    // Arbiter stand-in plus reference model, advanced together on each rising edge.
    always @(posedge clk) begin
        logic [N-1:0] pend;
        logic [N-1:0] nptr;
        int sel;
        bit found;
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k]  = 1'b0;
                m_issued[k] = 1'b0;
            end
            m_armed = 1'b0;
            arb_ptr  <= '0;
            arb_last <= N - 1;
        end else begin
            if (arvalid && arready) begin
                ar_ids.push_back(int'(arid));
                ar_cyc.push_back(cyc);
            end
            if (sche_en_o) begin
                nptr  = '0;
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    if (!found && queue_o[(arb_last + i) % N]) begin
                        found = 1'b1;
                        nptr[(arb_last + i) % N] = 1'b1;
                        arb_last <= (arb_last + i) % N;
                    end
                end
                arb_ptr <= nptr;
            end
            pend = m_pending();
            if (req_valid && m_occupied() < N) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && !m_valid[k]) begin
                        found = 1'b1;
                        m_valid[k]  = 1'b1;
                        m_issued[k] = 1'b0;
                        m_addr[k]   = req_addr;
                        m_len[k]    = req_len;
                    end
                end
            end
            if (!m_armed) begin
                if (pend != '0) m_armed = 1'b1;
            end else if (arb_ptr == '0) begin
                m_armed = 1'b0;
            end else if (arready) begin
                sel = ptr_index(arb_ptr);
                m_issued[sel] = 1'b1;
                m_armed = 1'b0;
            end
            if (rvalid && rready && rlast && int'(rid) < N) begin
                if (m_valid[rid] && m_issued[rid]) begin
                    m_valid[rid]  = 1'b0;
                    m_issued[rid] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_arv;
        int sel;
        if (chk_en) begin
            exp_arv = m_armed && (arb_ptr != '0);
            chk("req_ready", 64'(req_ready), 64'(m_occupied() < N));
            chk("queue_o", 64'(queue_o), 64'(m_pending()));
            chk("sche_en_o", 64'(sche_en_o), 64'(!m_armed && (m_pending() != '0)));
            chk("arvalid", 64'(arvalid), 64'(exp_arv));
            if (exp_arv) begin
                sel = ptr_index(arb_ptr);
                chk("araddr", 64'(araddr), 64'(m_addr[sel]));
                chk("arlen", 64'(arlen), 64'(m_len[sel]));
                chk("arid", 64'(arid), 64'(sel));
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst queue_o", 64'(queue_o), 64'd0);
        chk("rst sche_en", 64'(sche_en_o), 64'd0);
        chk("rst arvalid", 64'(arvalid), 64'd0);
        chk("rst araddr", 64'(araddr), 64'd0);
        chk("rst arlen", 64'(arlen), 64'd0);
        chk("rst arid", 64'(arid), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Single request through AR and completion
        req_valid = 1'b1; req_addr = 32'h1000; req_len = 8'd3;
        tick(1);
        req_valid = 1'b0;
        chk("t1 sche_en", 64'(sche_en_o), 64'd1);
        chk("t1 queue", 64'(queue_o), 64'h01);
        tick(1);
        chk("t1 arvalid", 64'(arvalid), 64'd1);
        chk("t1 araddr", 64'(araddr), 64'h1000);
        chk("t1 arlen", 64'(arlen), 64'd3);
        chk("t1 arid", 64'(arid), 64'd0);
        chk("t1 sche_off", 64'(sche_en_o), 64'd0);
        arready = 1'b1;
        tick(1);
        arready = 1'b0;
        chk("t1 queue_after_ar", 64'(queue_o), 64'd0);
        chk("t1 arvalid_after", 64'(arvalid), 64'd0);
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rid = 3'd0;
        tick(1);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        chk("t1 ready_after_r", 64'(req_ready), 64'd1);

        // Fill all slots with AR stalled, then a held-off ninth request
        for (int k = 0; k < N; k++) begin
            req_valid = 1'b1; req_addr = 32'h2000 + 32'(k * 16); req_len = LW'(k);
            tick(1);
        end
        chk("t2 full", 64'(req_ready), 64'd0);
        req_addr = 32'h9999; req_len = 8'hFF;
        tick(20);
        chk("t2 hold arvalid", 64'(arvalid), 64'd1);
        chk("t2 hold araddr", 64'(araddr), 64'h2000);
        chk("t2 hold arlen", 64'(arlen), 64'd0);
        chk("t2 hold arid", 64'(arid), 64'd0);
        chk("t2 still full", 64'(req_ready), 64'd0);

        // Reset while AR is pending
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick(1);
        chk("t6 arvalid", 64'(arvalid), 64'd0);
        chk("t6 queue", 64'(queue_o), 64'd0);
        chk("t6 ready", 64'(req_ready), 64'd1);
        chk("t6 sche_en", 64'(sche_en_o), 64'd0);
        rst_n = 1'b1;

        // Round-robin issue of slots 0..3 with AR always ready
        ar_ids.delete();
        ar_cyc.delete();
        arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 32'h3000 + 32'(k * 256); req_len = LW'(k + 1);
            tick(1);
        end
        req_valid = 1'b0;
        tick(8);
        arready = 1'b0;
        chk("t3 ar_count", 64'(ar_ids.size()), 64'd4);
        if (ar_ids.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3 ar_order", 64'(ar_ids[i]), 64'(i));
            for (int i = 1; i < 4; i++) chk("t3 ar_gap", 64'(ar_cyc[i] - ar_cyc[i-1]), 64'd2);
        end

        // Spurious R beats leave state untouched
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rid = 3'd5;
        tick(1);
        chk("t5 rid5 queue", 64'(queue_o), 64'd0);
        chk("t5 rid5 ready", 64'(req_ready), 64'd1);
        rlast = 1'b0; rid = 3'd1;
        tick(1);
        rvalid = 1'b0; rready = 1'b0;
        chk("t5 nolast queue", 64'(queue_o), 64'd0);
        chk("t5 nolast ready", 64'(req_ready), 64'd1);

        // Free and request in the same cycle while full
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 32'h4000 + 32'(k); req_len = LW'(16 + k);
            tick(1);
        end
        req_valid = 1'b0;
        chk("t4 full", 64'(req_ready), 64'd0);
        req_valid = 1'b1; req_addr = 32'hABC0; req_len = 8'd7;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; rid = 3'd2;
        tick(1);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        chk("t4 slot2 freed", 64'(queue_o[2]), 64'd0);
        chk("t4 ready after free", 64'(req_ready), 64'd1);
        tick(1);
        req_valid = 1'b0;
        chk("t4 slot2 refilled", 64'(queue_o[2]), 64'd1);
        chk("t4 full again", 64'(req_ready), 64'd0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
